// File: rtl/channel_in_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : channel_in_acc_ctrl_pkg
// Purpose  : Shared constants and types for the channel-in accumulation
//            sequencer: FSM state encoding, default counter width and the
//            tag latency that must match the data delay-line depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package channel_in_acc_ctrl_pkg;

  // Default width of pixel/pass counters and config fields.
  localparam int ACC_CNT_WIDTH = 12;

  // Depth of the channel-in data delay line. The tag pipeline uses the same
  // value so tags and data leave their pipelines on the same cycle.
  localparam int ACC_PIPE_DELAY = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_e;

endpackage : channel_in_acc_ctrl_pkg
`default_nettype wire

// File: rtl/channel_in_acc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : channel_in_acc_ctrl_if
// Purpose  : Bundles the layer-control side (start/config/beat valid) and the
//            accumulation-buffer side (tagged beat, busy/done/error) of the
//            channel-in accumulation sequencer.
// Modports : master - layer control / stimulus: drives start, cfg_*,
//                     data_valid_in; observes acc_*, busy, done, err_spurious
//            slave  - the sequencer itself (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface channel_in_acc_ctrl_if
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = ACC_CNT_WIDTH
);
  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_ch_in_times;
  logic [CNT_WIDTH-1:0] cfg_pixel_num;
  logic                 data_valid_in;
  logic                 acc_valid;
  logic                 acc_first;
  logic                 acc_last;
  logic [CNT_WIDTH-1:0] acc_addr;
  logic                 busy;
  logic                 done;
  logic                 err_spurious;

  modport master (
    output start, cfg_ch_in_times, cfg_pixel_num, data_valid_in,
    input  acc_valid, acc_first, acc_last, acc_addr, busy, done, err_spurious
  );

  modport slave (
    input  start, cfg_ch_in_times, cfg_pixel_num, data_valid_in,
    output acc_valid, acc_first, acc_last, acc_addr, busy, done, err_spurious
  );
endinterface : channel_in_acc_ctrl_if
`default_nettype wire

// File: rtl/channel_in_acc_ctrl_acc_tag_delay.sv
`default_nettype none
// ============================================================================
// Module   : acc_tag_delay
// Purpose  : DEPTH-stage register pipeline carrying the beat tag
//            {valid, first, last, addr}. A tag entering on cycle t appears at
//            the outputs on cycle t+DEPTH. Asynchronously cleared.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_first/in_last/in_addr    - tag entering this cycle
//            out_valid/out_first/out_last/out_addr - last pipeline stage
// Revision : 1.0 - initial release
// ============================================================================
module acc_tag_delay #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int TAG_W = ADDR_WIDTH + 3;

  logic [TAG_W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {in_valid, in_first, in_last, in_addr};
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {out_valid, out_first, out_last, out_addr} = r_pipe[DEPTH-1];

endmodule : acc_tag_delay
`default_nettype wire

// File: rtl/channel_in_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : channel_in_acc_ctrl
// Purpose  : Sequencer for the channel-in accumulation path. Counts passes
//            and pixels per pass, tags each accepted beat with first-pass /
//            last-pass flags and a pixel address, and delays the tag so it
//            lines up with the data leaving the channel-in delay line.
// Ports    : clk, rst_n (async active-low)
//            bus (slave) : start, cfg_ch_in_times (T), cfg_pixel_num (P),
//                          data_valid_in -> acc_valid, acc_first, acc_last,
//                          acc_addr, busy, done, err_spurious
// Revision : 1.0 - initial release
// ============================================================================
module channel_in_acc_ctrl
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = ACC_CNT_WIDTH,
  parameter int PIPE_DELAY = ACC_PIPE_DELAY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  channel_in_acc_ctrl_if.slave bus
);

  localparam int                   DRAIN_W      = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
  localparam logic [DRAIN_W-1:0]   C_DRAIN_LAST = DRAIN_W'(PIPE_DELAY - 1);
  localparam logic [DRAIN_W-1:0]   C_DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE        = CNT_WIDTH'(1);

  acc_state_e           r_state;
  logic [CNT_WIDTH-1:0] r_cfg_t;
  logic [CNT_WIDTH-1:0] r_cfg_p;
  logic [CNT_WIDTH-1:0] r_pix;
  logic [CNT_WIDTH-1:0] r_pass;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_start;
  logic w_beat;
  logic w_spurious;
  logic w_zero_cfg;
  logic w_pix_last;
  logic w_pass_last;
  logic w_pass_first;

  // Config is non-zero whenever RUN is entered, so T-1 / P-1 never wrap.
  assign w_start      = (r_state == ST_IDLE) && bus.start;
  assign w_beat       = (r_state == ST_RUN) && bus.data_valid_in;
  assign w_spurious   = (r_state != ST_RUN) && bus.data_valid_in;
  assign w_zero_cfg   = (bus.cfg_ch_in_times == '0) || (bus.cfg_pixel_num == '0);
  assign w_pix_last   = (r_pix == (r_cfg_p - C_ONE));
  assign w_pass_last  = (r_pass == (r_cfg_t - C_ONE));
  assign w_pass_first = (r_pass == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cfg_t <= '0;
      r_cfg_p <= '0;
      r_pix   <= '0;
      r_pass  <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A spurious beat in the same cycle as an accepted start still flags.
      r_err  <= (w_start ? 1'b0 : r_err) | w_spurious;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cfg_t <= bus.cfg_ch_in_times;
            r_cfg_p <= bus.cfg_pixel_num;
            r_pix   <= '0;
            r_pass  <= '0;
            if (w_zero_cfg) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (w_beat) begin
            if (w_pix_last) begin
              r_pix  <= '0;
              r_pass <= r_pass + C_ONE;
              if (w_pass_last) begin
                r_state <= ST_DRAIN;
                r_drain <= '0;
              end
            end else begin
              r_pix <= r_pix + C_ONE;
            end
          end
        end

        // Wait until the final tag has left the pipeline.
        ST_DRAIN: begin
          if (r_drain == C_DRAIN_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + C_DRAIN_ONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Outside RUN the pipeline is fed valid=0 bubbles; the other tag fields of
  // such slots carry whatever the counters hold and are ignored downstream.
  acc_tag_delay #(
    .ADDR_WIDTH (CNT_WIDTH),
    .DEPTH      (PIPE_DELAY)
  ) u_tag_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_beat),
    .in_first  (w_pass_first),
    .in_last   (w_pass_last),
    .in_addr   (r_pix),
    .out_valid (bus.acc_valid),
    .out_first (bus.acc_first),
    .out_last  (bus.acc_last),
    .out_addr  (bus.acc_addr)
  );

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err_spurious = r_err;

endmodule : channel_in_acc_ctrl
`default_nettype wire
